sw_led_ctrl: RTL and testbench

Mode controller for the 16-switch / 16-LED bank on the board.
- Synchronises and debounces the slide switches and one mode push-button.
- Steps a 4-mode state machine on each button press: pass-through, hold, rotate and blink.
- Drives the LED bus from registered state.
- Sits between the board switch/button pins and the LED pins, in place of a direct wire.

---
 rtl/sw_led_ctrl.sv | 142 ++++++++++++++
 tb/tb_sw_led_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_led_ctrl.sv
// Mode controller for the switch/LED bank: synchronises and debounces the slide
// switches and mode button, then drives the LEDs in pass, hold, rotate or blink mode.
module sw_led_ctrl #(
  parameter int N           = 16,
  parameter int DEB_CYCLES  = 1000000,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         btn_mode,
  output logic [N-1:0] led,
  output logic [1:0]   mode
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    HOLD  = 2'd1,
    SHIFT = 2'd2,
    BLINK = 2'd3
  } mode_e;

  logic [N-1:0]  sw_m, sw_s, sw_prev, sw_db;
  logic          btn_m, btn_s, btn_prev, btn_db, btn_db_d;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] tick_cnt;
  logic          samp, step, tick;

  mode_e         state, state_nxt;
  logic [N-1:0]  pattern, pattern_nxt, led_nxt;
  logic          blink_on, blink_on_nxt;

  assign samp = (deb_cnt == DEB_LAST);
  assign tick = (tick_cnt == TICK_LAST);
  assign step = btn_db & ~btn_db_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      btn_m <= btn_mode;
      btn_s <= btn_m;
    end
  end

  // A bit only moves when two consecutive samples agree on its new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt  <= '0;
      sw_prev  <= '0;
      sw_db    <= '0;
      btn_prev <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (samp) begin
        deb_cnt  <= '0;
        sw_prev  <= sw_s;
        sw_db    <= (sw_s & ~(sw_s ^ sw_prev)) | (sw_db & (sw_s ^ sw_prev));
        btn_prev <= btn_s;
        if (btn_s == btn_prev) btn_db <= btn_s;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tick_cnt <= '0;
    else if (step || tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PASS;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    pattern_nxt  = pattern;
    blink_on_nxt = blink_on;
    led_nxt      = '0;
    unique case (state)
      PASS: begin
        led_nxt = sw_db;
        if (step) begin
          state_nxt   = HOLD;
          pattern_nxt = sw_db;
        end
      end
      HOLD: begin
        led_nxt = pattern;
        if (step) state_nxt = SHIFT;
      end
      SHIFT: begin
        led_nxt = pattern;
        if (step) begin
          state_nxt    = BLINK;
          blink_on_nxt = 1'b1;
        end else if (tick) begin
          pattern_nxt = {pattern[N-2:0], pattern[N-1]};
        end
      end
      BLINK: begin
        led_nxt = blink_on ? pattern : '0;
        if (step)      state_nxt    = PASS;
        else if (tick) blink_on_nxt = ~blink_on;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern  <= '0;
      blink_on <= 1'b0;
      led      <= '0;
      mode     <= PASS;
    end else begin
      pattern  <= pattern_nxt;
      blink_on <= blink_on_nxt;
      led      <= led_nxt;
      mode     <= state;
    end
  end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl with short debounce/tick periods:
// PASS vector table plus hand-timed hold, rotate, blink, step/tick and reset sequences.
module tb_sw_led_ctrl;

  localparam int N    = 16;
  localparam int DEB  = 4;
  localparam int TICK = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] sw = '0;
  logic         btn_mode = 1'b0;
  logic [N-1:0] led;
  logic [1:0]   mode;

  int checks   = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] exp_led;
    logic [1:0]  exp_mode;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] led;
    logic [1:0]  mode;
    bit          chk_led;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  sw_led_ctrl #(.N(N), .DEB_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_mode (btn_mode),
    .led      (led),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; DUT debounce samples fall on multiples of DEB.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [15:0] l, input logic [1:0] m,
                         input bit chk_led);
    exp_t e;
    e.name = name; e.led = l; e.mode = m; e.chk_led = chk_led;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb.pop_front();
      check({e.name, "_mode"}, {30'd0, mode}, {30'd0, e.mode});
      if (e.chk_led) check({e.name, "_led"}, {16'd0, led}, {16'd0, e.led});
    end
  endtask

  // Press the button after letting any earlier release settle; returns at the
  // first negedge where mode has moved (bounded), with the button released.
  task automatic press(input string name, input logic [1:0] exp_mode,
                       input logic [15:0] exp_led, input bit chk_led);
    logic [1:0] old;
    int n;
    repeat (12) @(negedge clk);
    old = mode;
    sb_push(name, exp_led, exp_mode, chk_led);
    btn_mode = 1'b1;
    n = 0;
    while (mode == old && n < 40) begin
      @(negedge clk);
      n++;
    end
    btn_mode = 1'b0;
    sb_check();
  endtask

  initial begin
    int m, es, t, guard;
    logic bad;
    logic [15:0] p;

    vecs[0] = '{sw: 16'hA5C3, exp_led: 16'hA5C3, exp_mode: 2'd0};
    vecs[1] = '{sw: 16'h0000, exp_led: 16'h0000, exp_mode: 2'd0};
    vecs[2] = '{sw: 16'hFFFF, exp_led: 16'hFFFF, exp_mode: 2'd0};
    vecs[3] = '{sw: 16'h0001, exp_led: 16'h0001, exp_mode: 2'd0};
    vecs[4] = '{sw: 16'h8000, exp_led: 16'h8000, exp_mode: 2'd0};
    vecs[5] = '{sw: 16'h5A5A, exp_led: 16'h5A5A, exp_mode: 2'd0};

    // Reset, then first debounced value appears after the second agreeing sample.
    sw = 16'hA5C3;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", {16'd0, led}, 32'h0);
    check("reset_mode", {30'd0, mode}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("pass_not_early", {16'd0, led}, 32'h0);
    @(negedge clk);
    check("pass_latency", {16'd0, led}, 32'hA5C3);

    for (int i = 0; i < 6; i++) begin
      sw = vecs[i].sw;
      sb_push($sformatf("pass_vec%0d", i), vecs[i].exp_led, vecs[i].exp_mode, 1'b1);
      repeat (12) @(negedge clk);
      sb_check();
    end

    // Short glitches must never reach the debounced outputs.
    sw = 16'h0000;
    repeat (12) @(negedge clk);
    bad = 1'b0;
    sw[0] = 1'b1;
    repeat (3) @(negedge clk);
    sw[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (led[0]) bad = 1'b1;
    end
    check("sw_glitch_rejected", {31'd0, bad}, 32'h0);
    bad = 1'b0;
    btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    btn_mode = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mode != 2'd0) bad = 1'b1;
    end
    check("btn_glitch_rejected", {31'd0, bad}, 32'h0);

    // HOLD capture and switch independence, then walk round to PASS.
    sw = 16'h00F0;
    repeat (12) @(negedge clk);
    check("pass_00f0", {16'd0, led}, 32'h00F0);
    press("hold_capture", 2'd1, 16'h00F0, 1'b1);
    sw = 16'hFFFF;
    repeat (14) @(negedge clk);
    check("hold_ignores_sw", {16'd0, led}, 32'h00F0);
    press("enter_shift_f0", 2'd2, 16'h00F0, 1'b1);
    press("enter_blink_f0", 2'd3, 16'h0000, 1'b0);
    press("blink_to_pass", 2'd0, 16'hFFFF, 1'b1);

    // SHIFT timing relative to the step.
    sw = 16'h8001;
    repeat (12) @(negedge clk);
    press("hold_8001", 2'd1, 16'h8001, 1'b1);
    press("shift_8001", 2'd2, 16'h8001, 1'b1);
    m = cyc;
    repeat (7) @(negedge clk);
    check("shift_before_tick", {16'd0, led}, 32'h8001);
    @(negedge clk);
    check("shift_tick1", {16'd0, led}, 32'h0003);
    repeat (7) @(negedge clk);
    check("shift_hold_between", {16'd0, led}, 32'h0003);
    @(negedge clk);
    check("shift_tick2", {16'd0, led}, 32'h0006);

    // Align the next step with the 5th tick; the rotate must be discarded.
    es = m - 1;
    t = es + 5 * TICK;
    guard = 0;
    while (cyc != t - 8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("align_reached", cyc, t - 8);
    btn_mode = 1'b1;
    repeat (8) @(negedge clk);
    check("step_tick_mode_before", {30'd0, mode}, 32'd2);
    @(negedge clk);
    btn_mode = 1'b0;
    p = rotl(16'h8001, 4);
    check("step_tick_mode", {30'd0, mode}, 32'd3);
    check("step_tick_no_rotate", {16'd0, led}, {16'd0, p});

    // BLINK phases from the entry.
    repeat (7) @(negedge clk);
    check("blink_on_phase", {16'd0, led}, {16'd0, p});
    @(negedge clk);
    check("blink_off", {16'd0, led}, 32'h0);
    repeat (7) @(negedge clk);
    check("blink_off_hold", {16'd0, led}, 32'h0);
    @(negedge clk);
    check("blink_on_again", {16'd0, led}, {16'd0, p});

    // Asynchronous reset mid-BLINK, sampled before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", {16'd0, led}, 32'h0);
    check("async_reset_mode", {30'd0, mode}, 32'h0);

    // All-zero pattern stays constant under rotation.
    sw = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    press("hold_zero", 2'd1, 16'h0000, 1'b1);
    press("shift_zero", 2'd2, 16'h0000, 1'b1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (led != 16'h0000) bad = 1'b1;
    end
    check("shift_zero_constant", {31'd0, bad}, 32'h0);
    check("shift_zero_mode", {30'd0, mode}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
